// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
//
// Parametrised integer register file for the BLI RISC-V cores (IDU).
// Written from WB, read combinationally by decode. After every reset a
// hardware clear sequence zeroes x1..x(NREG-1) before accesses are honoured.
// Any index at or beyond NREG seen while ready raises a sticky illegal flag.
//
// Parameters:
//   XLEN   data width (32 or 64)
//   NREG   architectural register count including x0 (16 or 32)
//   BYPASS 1 = same-cycle write data forwarded to matching read ports
//
// Ports:
//   clk                 rising-edge clock
//   rst_n               synchronous active-low reset
//   regfile_i_rd_addr   write index
//   regfile_i_w_en      write enable
//   regfile_i_rd_data   write data
//   regfile_i_rs1_addr  read port 1 index
//   regfile_o_rs1_data  read port 1 data (combinational)
//   regfile_i_rs2_addr  read port 2 index
//   regfile_o_rs2_data  read port 2 data (combinational)
//   regfile_o_ready     clear sequence finished, accesses honoured
//   regfile_o_illegal   sticky out-of-range access flag
// ---------------------------------------------------------------------------
module regfile_param #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      regfile_i_rd_addr,
    input  logic            regfile_i_w_en,
    input  logic [XLEN-1:0] regfile_i_rd_data,
    input  logic [4:0]      regfile_i_rs1_addr,
    output logic [XLEN-1:0] regfile_o_rs1_data,
    input  logic [4:0]      regfile_i_rs2_addr,
    output logic [XLEN-1:0] regfile_o_rs2_data,
    output logic            regfile_o_ready,
    output logic            regfile_o_illegal
);

    localparam int IW = $clog2(NREG);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]      state_q;
    logic [0:0]      state_d;
    logic [IW-1:0]   clr_idx_q;
    logic [IW-1:0]   clr_idx_d;
    logic            illegal_q;
    logic            illegal_d;

    // x0 has no storage; entries cover x1..x(NREG-1) only.
    logic [XLEN-1:0] mem_q [1:NREG-1];

    logic            ready_s;
    logic            wr_legal_s;
    logic            access_illegal_s;
    logic            mem_we_s;
    logic [IW-1:0]   mem_waddr_s;
    logic [XLEN-1:0] mem_wdata_s;

    // Only the index bits at and above IW decide illegality, so with
    // NREG=32 the shifted value is always zero and the flag never sets.
    function automatic logic idx_illegal(input logic [4:0] idx);
        logic [4:0] hi;
        hi = idx >> IW;
        return (hi != 5'd0);
    endfunction

    // Read mux: gated to zero until the clear sequence completes, x0 and
    // out-of-range indices read zero, optional same-cycle forwarding.
    function automatic logic [XLEN-1:0] read_port(input logic [4:0] idx);
        logic [XLEN-1:0] val;
        if (!ready_s) begin
            val = '0;
        end else if ((idx == 5'd0) || idx_illegal(idx)) begin
            val = '0;
        end else if ((BYPASS != 0) && wr_legal_s && (regfile_i_rd_addr == idx)) begin
            val = regfile_i_rd_data;
        end else begin
            val = mem_q[idx[IW-1:0]];
        end
        return val;
    endfunction

    assign ready_s    = (state_q == ST_READY);
    assign wr_legal_s = ready_s && regfile_i_w_en
                        && (regfile_i_rd_addr != 5'd0)
                        && !idx_illegal(regfile_i_rd_addr);
    // Read ports count as accessed every cycle; the write port only when enabled.
    assign access_illegal_s = (regfile_i_w_en && idx_illegal(regfile_i_rd_addr))
                              || idx_illegal(regfile_i_rs1_addr)
                              || idx_illegal(regfile_i_rs2_addr);

    // Next-state logic for the clear sequencer, illegal flag and write port.
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        illegal_d   = illegal_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = regfile_i_rd_addr[IW-1:0];
        mem_wdata_s = regfile_i_rd_data;
        case (state_q)
            ST_CLEAR: begin
                // User writes are ignored; the sequencer owns the write port.
                mem_we_s    = 1'b1;
                mem_waddr_s = clr_idx_q;
                mem_wdata_s = '0;
                clr_idx_d   = clr_idx_q + IW'(1);
                if (clr_idx_q == IW'(NREG - 1)) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_READY: begin
                mem_we_s = wr_legal_s;
                if (access_illegal_s) begin
                    illegal_d = 1'b1;
                end else begin
                    illegal_d = illegal_q;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = IW'(1);
            end
        endcase
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= IW'(1);
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            illegal_q <= illegal_d;
        end
    end

    // Storage write port; no write on a reset edge.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Combinational read ports.
    always_comb begin
        regfile_o_rs1_data = read_port(regfile_i_rs1_addr);
        regfile_o_rs2_data = read_port(regfile_i_rs2_addr);
    end

    assign regfile_o_ready   = ready_s;
    assign regfile_o_illegal = illegal_q;

endmodule

// File: tb/tb_regfile_param.sv
// ---------------------------------------------------------------------------
// tb_regfile_param
//
// Four regfile_param instances share one stimulus stream:
//   0: XLEN=32 NREG=32 BYPASS=1
//   1: XLEN=32 NREG=32 BYPASS=0
//   2: XLEN=32 NREG=16 BYPASS=1 (RV32E)
//   3: XLEN=64 NREG=32 BYPASS=1 (RV64I)
// A behavioural model (clear-edge counter, plain register arrays, sticky
// flag) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rd = 5'd0;
    logic        w_en = 1'b0;
    logic [63:0] wd = 64'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;

    logic [31:0] rs1_0, rs2_0, rs1_1, rs2_1, rs1_2, rs2_2;
    logic [63:0] rs1_3, rs2_3;
    logic        rdy [4];
    logic        ill [4];
    logic [63:0] rs1_o [4];
    logic [63:0] rs2_o [4];

    int total = 0;
    int bad   = 0;

    // model configuration and state
    int          m_nreg [4] = '{32, 32, 16, 32};
    int          m_xlen [4] = '{32, 32, 32, 64};
    int          m_byp  [4] = '{1, 0, 1, 1};
    int          m_cnt  [4] = '{0, 0, 0, 0};
    logic        m_ill  [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [63:0] m_mem  [4][32];

    always #5 clk = ~clk;

    regfile_param #(.XLEN(32), .NREG(32), .BYPASS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .regfile_i_rd_addr(rd), .regfile_i_w_en(w_en),
        .regfile_i_rd_data(wd[31:0]), .regfile_i_rs1_addr(rs1), .regfile_o_rs1_data(rs1_0),
        .regfile_i_rs2_addr(rs2), .regfile_o_rs2_data(rs2_0),
        .regfile_o_ready(rdy[0]), .regfile_o_illegal(ill[0]));
    regfile_param #(.XLEN(32), .NREG(32), .BYPASS(0)) u1 (
        .clk(clk), .rst_n(rst_n), .regfile_i_rd_addr(rd), .regfile_i_w_en(w_en),
        .regfile_i_rd_data(wd[31:0]), .regfile_i_rs1_addr(rs1), .regfile_o_rs1_data(rs1_1),
        .regfile_i_rs2_addr(rs2), .regfile_o_rs2_data(rs2_1),
        .regfile_o_ready(rdy[1]), .regfile_o_illegal(ill[1]));
    regfile_param #(.XLEN(32), .NREG(16), .BYPASS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .regfile_i_rd_addr(rd), .regfile_i_w_en(w_en),
        .regfile_i_rd_data(wd[31:0]), .regfile_i_rs1_addr(rs1), .regfile_o_rs1_data(rs1_2),
        .regfile_i_rs2_addr(rs2), .regfile_o_rs2_data(rs2_2),
        .regfile_o_ready(rdy[2]), .regfile_o_illegal(ill[2]));
    regfile_param #(.XLEN(64), .NREG(32), .BYPASS(1)) u3 (
        .clk(clk), .rst_n(rst_n), .regfile_i_rd_addr(rd), .regfile_i_w_en(w_en),
        .regfile_i_rd_data(wd), .regfile_i_rs1_addr(rs1), .regfile_o_rs1_data(rs1_3),
        .regfile_i_rs2_addr(rs2), .regfile_o_rs2_data(rs2_3),
        .regfile_o_ready(rdy[3]), .regfile_o_illegal(ill[3]));

    assign rs1_o[0] = {32'd0, rs1_0};
    assign rs2_o[0] = {32'd0, rs2_0};
    assign rs1_o[1] = {32'd0, rs1_1};
    assign rs2_o[1] = {32'd0, rs2_1};
    assign rs1_o[2] = {32'd0, rs1_2};
    assign rs2_o[2] = {32'd0, rs2_2};
    assign rs1_o[3] = rs1_3;
    assign rs2_o[3] = rs2_3;

    function automatic logic [63:0] mask(input int i);
        return (m_xlen[i] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic m_ready(input int i);
        return (m_cnt[i] >= m_nreg[i] - 1);
    endfunction

    function automatic logic [63:0] exp_read(input int i, input logic [4:0] a);
        if (!m_ready(i)) return 64'd0;
        if (a == 5'd0 || int'(a) >= m_nreg[i]) return 64'd0;
        if (m_byp[i] != 0 && w_en && rd == a) return wd & mask(i);
        return m_mem[i][a];
    endfunction

    // compare every output of every instance against the model
    task automatic check_all();
        logic [63:0] e1, e2;
        for (int i = 0; i < 4; i++) begin
            e1 = exp_read(i, rs1);
            e2 = exp_read(i, rs2);
            total++;
            assert (rs1_o[i] === e1) else begin
                bad++; $error("FAIL rs1 inst=%0d addr=%0d got=%h exp=%h", i, rs1, rs1_o[i], e1);
            end
            total++;
            assert (rs2_o[i] === e2) else begin
                bad++; $error("FAIL rs2 inst=%0d addr=%0d got=%h exp=%h", i, rs2, rs2_o[i], e2);
            end
            total++;
            assert (rdy[i] === m_ready(i)) else begin
                bad++; $error("FAIL ready inst=%0d got=%b exp=%b", i, rdy[i], m_ready(i));
            end
            total++;
            assert (ill[i] === m_ill[i]) else begin
                bad++; $error("FAIL illegal inst=%0d got=%b exp=%b", i, ill[i], m_ill[i]);
            end
        end
    endtask

    // apply one rising edge to the model
    task automatic model_edge();
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                m_cnt[i] = 0;
                m_ill[i] = 1'b0;
                for (int j = 0; j < 32; j++) m_mem[i][j] = 64'd0;
            end else if (!m_ready(i)) begin
                m_cnt[i]++;
            end else begin
                if (w_en) begin
                    if (int'(rd) >= m_nreg[i]) m_ill[i] = 1'b1;
                    else if (rd != 5'd0) m_mem[i][rd] = wd & mask(i);
                end
                if (int'(rs1) >= m_nreg[i] || int'(rs2) >= m_nreg[i]) m_ill[i] = 1'b1;
            end
        end
    endtask

    // check before the edge, clock, update model, move off the edge
    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] a_rd, input logic [63:0] d,
                         input logic [4:0] a1, input logic [4:0] a2);
        w_en = we; rd = a_rd; wd = d; rs1 = a1; rs2 = a2;
    endtask

    initial begin
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 32; j++) m_mem[i][j] = 64'd0;

        // reset held for three edges, then the clear sequence with a write attempt
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        for (int k = 0; k < 31; k++) begin
            drive(1'b1, 5'd3, 64'h0BAD_0BAD_0BAD_0BAD, 5'd3, 5'd1);
            step();
        end
        // zero check on the low half
        for (int k = 1; k < 16; k++) begin
            drive(1'b0, 5'd0, 64'd0, 5'(k), 5'(16 - k));
            step();
        end

        // write x5 then read it; x0 ignores writes
        drive(1'b1, 5'd5, 64'h0000_0000_DEAD_BEEF, 5'd0, 5'd0); step();
        drive(1'b0, 5'd0, 64'd0, 5'd5, 5'd0);                   step();
        drive(1'b1, 5'd0, 64'h0000_0000_0000_1234, 5'd0, 5'd0); step();
        drive(1'b0, 5'd0, 64'd0, 5'd5, 5'd0);                   step();

        // bypass: old value in x7, then write and read x7 in the same cycle
        drive(1'b1, 5'd7, 64'h1111_1111_1111_1111, 5'd0, 5'd0); step();
        drive(1'b1, 5'd7, 64'h0000_0000_A5A5_A5A5, 5'd7, 5'd7); step();
        drive(1'b0, 5'd0, 64'd0, 5'd7, 5'd7);                   step();

        // RV32E: write to x20 dropped and flagged, read of x17 returns 0
        drive(1'b1, 5'd20, 64'h0000_0000_2020_2020, 5'd1, 5'd1); step();
        drive(1'b0, 5'd0, 64'd0, 5'd20, 5'd17);                  step();

        // RV64: full-width value in x31
        drive(1'b1, 5'd31, 64'hFFFF_0000_1234_5678, 5'd0, 5'd0); step();
        drive(1'b0, 5'd0, 64'd0, 5'd31, 5'd5);                   step();

        // write and illegal read in the same cycle
        drive(1'b1, 5'd9, 64'h9999_9999_9999_9999, 5'd18, 5'd9); step();
        drive(1'b0, 5'd0, 64'd0, 5'd9, 5'd9);                    step();

        // remaining high registers
        for (int k = 16; k < 32; k++) begin
            drive(1'b0, 5'd0, 64'd0, 5'(k), 5'(k - 15));
            step();
        end

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  {$urandom, $urandom}, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            step();
        end

        // reset in READY, then a reset pulse on the 10th clear edge
        drive(1'b1, 5'd3, 64'h3333_3333_3333_3333, 5'd3, 5'd3); step();
        drive(1'b0, 5'd0, 64'd0, 5'd3, 5'd3);
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        repeat (9) step();
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        repeat (31) step();
        // after the clear everything reads zero, including x3
        for (int k = 1; k < 32; k++) begin
            drive(1'b0, 5'd0, 64'd0, 5'd3, 5'(k));
            step();
        end

        // a few more random cycles after the rerun clear
        for (int k = 0; k < 100; k++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  {$urandom, $urandom}, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised integer register file for the BLI RISC-V cores, the successor to the fixed 32×32 regfile in the IDU. It adds configurable XLEN and register count (RV32I/RV32E/RV64I), optional same-cycle write-to-read bypass, and a hardware clear sequence that zeroes every architectural register after reset. It adds a sticky illegal-access flag for register indices beyond the configured count. It sits in the IDU, is written from the WB stage, and is read combinationally by decode.

## Interface
- XLEN, 32, data width in bits (32 or 64)
- NREG, 32, architectural register count including x0 (16 or 32)
- BYPASS, 1, 1 = a write in the current cycle is forwarded to matching read ports; 0 = no forwarding
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  synchronous active-low reset; one clock; reset is synchronous and active-low
- regfile_i_rd_addr  input  5  write index
- regfile_i_w_en  input  1  write enable
- regfile_i_rd_data  input  XLEN  write data
- regfile_i_rs1_addr  input  5  read port 1 index
- regfile_o_rs1_data  output  XLEN  read port 1 data
- regfile_i_rs2_addr  input  5  read port 2 index
- regfile_o_rs2_data  output  XLEN  read port 2 data
- regfile_o_ready  output  1  1 = clear sequence done, accesses honoured
- regfile_o_illegal  output  1  sticky: an index ≥ NREG was accessed while ready

## Operation
- Storage: NREG-1 entries of XLEN bits for x1..x(NREG-1). x0 has no storage. x0 always reads 0 and ignores writes.
- States: CLEAR, READY. Index counter clr_idx is $clog2(NREG) bits.
- rst_n=0 at an edge:
  - state←CLEAR, clr_idx←1, illegal←0.
  - No storage write on that edge.
- CLEAR with rst_n=1:
  - Each edge writes 0 to entry clr_idx and increments clr_idx.
  - The edge that writes entry NREG-1 also sets state←READY.
  - User writes are dropped. Read ports output 0. illegal does not update.
- READY, write:
  - Occurs when w_en=1, rd_addr≠0 and rd_addr<NREG; entry is updated at the edge.
  - rd_addr≥NREG: write dropped, illegal←1.
- READY, read:
  - Combinational (distributed RAM).
  - Index 0 or index ≥NREG returns 0.
  - Any index ≥NREG on rs1 or rs2 sets illegal←1 at the edge. Read-port indices are always treated as accessed.
- Bypass (BYPASS=1, READY, w_en=1, rd_addr=rsN_addr, 1≤rd_addr<NREG): rsN_data=rd_data in the same cycle.
  - BYPASS=0: rsN_data shows the old value until after the edge.
- Illegal is sticky until reset. Only bits [4:$clog2(NREG)] of an index determine illegality. For NREG=32 illegal can never assert.

## Timing
- Reset values: regfile_o_ready=0, regfile_o_illegal=0, rs1/rs2 data=0, state CLEAR, clr_idx=1.
- Clear latency is NREG-1 edges after the first edge sampled with rst_n=1.
  - ready rises after the 31st such edge for NREG=32, and after the 15th for NREG=16.
- Read latency is 0 cycles (combinational). Write-to-read latency is 1 edge, or 0 with BYPASS=1.
- rst_n low mid-CLEAR: the sequence restarts from index 1 and the full NREG-1 edges are needed again.
- rst_n low in READY: ready falls after that edge, then the clear reruns and all entries end 0.
- Simultaneous write and read of the same index:
  - BYPASS=1 returns the new data.
  - BYPASS=0 returns the old data.
  - Both ports may hit the same index at once.
- Write and illegal read in the same cycle: the write is honoured and illegal is set.

## Test plan
- Clear sequence, NREG=32: hold rst_n=0 for 3 edges, then release. Required response:
  - ready=0 for 30 edges and =1 after the 31st edge.
  - A w_en write during CLEAR is ignored.
  - Reading x1..x31 then returns 0.
- Write/read and x0: write 0xDEADBEEF to x5, read rs1=5 next cycle → 0xDEADBEEF. Write 0x1234 to x0, read rs2=0 → 0.
- Bypass, BYPASS=1: in one cycle, w_en=1, rd=7, data=0xA5A5A5A5, rs1=rs2=7 → both ports show 0xA5A5A5A5 that cycle.
  - Same stimulus with BYPASS=0 → the old value.
- RV32E, NREG=16:
  - A write to x20 is dropped and illegal=1 after the edge.
  - Reading rs2=17 returns 0.
  - illegal stays 1 until rst_n=0.
- Reset mid-clear: pulse rst_n=0 at the 10th clear edge → ready rises only after 31 further edges, and x3 written before reset reads 0.
- RV64, XLEN=64: write 0xFFFF_0000_1234_5678 to x31 → rs1=31 reads the full 64-bit value with no truncation.
